// File: rtl/andor_arbiter_pkg.sv
// Shared definitions for andor_arbiter: FSM state encoding, parameter
// defaults and the round-robin pick helper.
package andor_arbiter_pkg;

  localparam int unsigned ANDOR_W_DEFAULT     = 2;
  localparam int unsigned ANDOR_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Winner id for the current requests: a lone requester wins outright,
  // and a tie goes to the requester that was not granted last.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

endpackage

// File: rtl/andor_arbiter_and_or_unit.sv
// Combinational W-bit AND/OR datapath used by andor_arbiter.
module and_or_unit #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y_and,
  output logic [W-1:0] y_or
);

  // Bitwise results of the two operands.
  always_comb begin
    y_and = a & b;
    y_or  = a | b;
  end

endmodule

// File: rtl/andor_arbiter.sv
// Two-requester round-robin arbiter that computes AND/OR of the granted
// operand pair. Each transaction takes IDLE -> CALC -> DONE and ends with
// a one-cycle done pulse for the granted requester.
// Optional grant counters gcnt0/gcnt1 are built only when the macro
// ANDOR_ARB_STATS_EN is defined.
module andor_arbiter
  import andor_arbiter_pkg::*;
#(
  parameter int unsigned W     = ANDOR_W_DEFAULT,
  parameter int unsigned CNT_W = ANDOR_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [W-1:0]     x0,
  input  logic [W-1:0]     y0,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     y1,
  output logic [W-1:0]     res_and,
  output logic [W-1:0]     res_or,
  output logic             done0,
  output logic             done1,
  output logic             busy
`ifdef ANDOR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
`endif
);

  if (W == 0) begin : g_w_chk
    $error("andor_arbiter: W must be nonzero");
  end
  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("andor_arbiter: CNT_W must be nonzero");
  end

  state_e         state_q, state_d;
  logic           gid_q, gid_d;
  logic           last_q, last_d;
  logic [W-1:0]   xg_q, xg_d;
  logic [W-1:0]   yg_q, yg_d;
  logic [W-1:0]   res_and_q, res_and_d;
  logic [W-1:0]   res_or_q, res_or_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;
  logic [W-1:0]   au_and;
  logic [W-1:0]   au_or;

  and_or_unit #(
    .W(W)
  ) u_and_or (
    .a     (xg_q),
    .b     (yg_q),
    .y_and (au_and),
    .y_or  (au_or)
  );

  // Next-state and datapath control; operands are captured only when
  // leaving IDLE so later operand changes cannot reach the result.
  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    last_d    = last_q;
    xg_d      = xg_q;
    yg_d      = yg_q;
    res_and_d = res_and_q;
    res_or_d  = res_or_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gid_d   = rr_pick(req0, req1, last_q);
          xg_d    = gid_d ? x1 : x0;
          yg_d    = gid_d ? y1 : y0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_and_d = au_and;
        res_or_d  = au_or;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done0_d = ~gid_q;
        done1_d = gid_q;
        last_d  = gid_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset favours requester 0 for the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gid_q     <= 1'b0;
      last_q    <= 1'b1;
      xg_q      <= '0;
      yg_q      <= '0;
      res_and_q <= '0;
      res_or_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      xg_q      <= xg_d;
      yg_q      <= yg_d;
      res_and_q <= res_and_d;
      res_or_q  <= res_or_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  // Output drive.
  always_comb begin
    res_and = res_and_q;
    res_or  = res_or_q;
    done0   = done0_q;
    done1   = done1_q;
    busy    = (state_q != ST_IDLE);
  end

`ifdef ANDOR_ARB_STATS_EN
  logic             grant_vld;
  logic [CNT_W-1:0] gcnt0_q, gcnt0_d;
  logic [CNT_W-1:0] gcnt1_q, gcnt1_d;

  // Saturating grant counters, bumped on each IDLE -> CALC grant.
  always_comb begin
    grant_vld = (state_q == ST_IDLE) && (req0 || req1);
    gcnt0_d   = gcnt0_q;
    gcnt1_d   = gcnt1_q;
    if (grant_vld && !gid_d && (gcnt0_q != '1)) begin
      gcnt0_d = gcnt0_q + CNT_W'(1);
    end
    if (grant_vld && gid_d && (gcnt1_q != '1)) begin
      gcnt1_d = gcnt1_q + CNT_W'(1);
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  // Counter output drive.
  always_comb begin
    gcnt0 = gcnt0_q;
    gcnt1 = gcnt1_q;
  end
`endif

endmodule

// File: tb/tb_andor_arbiter.sv
// Self-checking bench for andor_arbiter: a transaction-level model is
// compared every cycle, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_andor_arbiter;

  localparam int unsigned W = 2;
`ifdef ANDOR_ARB_STATS_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 8;
`endif
  localparam int GMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [W-1:0] res_and, res_or;
  logic done0, done1, busy;
`ifdef ANDOR_ARB_STATS_EN
  logic [CW-1:0] gcnt0, gcnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  andor_arbiter #(
    .W     (W),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .res_and (res_and),
    .res_or  (res_or),
    .done0   (done0),
    .done1   (done1),
    .busy    (busy)
`ifdef ANDOR_ARB_STATS_EN
    ,
    .gcnt0   (gcnt0),
    .gcnt1   (gcnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant computes its result at once; the result
  // becomes visible one edge later and the done pulse one edge after that.
  int           m_phase = -1;  // -1 free, 0 result pending, 1 done pending
  logic         m_last  = 1'b1;
  logic         m_gid   = 1'b0;
  logic [W-1:0] m_and = '0, m_or = '0, p_and = '0, p_or = '0;
  logic         m_d0 = 1'b0, m_d1 = 1'b0;
  int           m_gc0 = 0, m_gc1 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= -1;
      m_last  <= 1'b1;
      m_and   <= '0;
      m_or    <= '0;
      m_d0    <= 1'b0;
      m_d1    <= 1'b0;
      m_gc0   <= 0;
      m_gc1   <= 0;
    end else begin
      m_d0 <= 1'b0;
      m_d1 <= 1'b0;
      if (m_phase == -1) begin
        if (req0 || req1) begin
          if ((req0 && req1) ? !m_last : req1) begin
            m_gid <= 1'b1;
            p_and <= x1 & y1;
            p_or  <= x1 | y1;
            if (m_gc1 < GMAX) m_gc1 <= m_gc1 + 1;
          end else begin
            m_gid <= 1'b0;
            p_and <= x0 & y0;
            p_or  <= x0 | y0;
            if (m_gc0 < GMAX) m_gc0 <= m_gc0 + 1;
          end
          m_phase <= 0;
        end
      end else if (m_phase == 0) begin
        m_and   <= p_and;
        m_or    <= p_or;
        m_phase <= 1;
      end else begin
        if (m_gid) m_d1 <= 1'b1;
        else       m_d0 <= 1'b1;
        m_last  <= m_gid;
        m_phase <= -1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_res_and", res_and, m_and);
      check("model_res_or", res_or, m_or);
      check("model_done0", done0, m_d0);
      check("model_done1", done1, m_d1);
      check("model_busy", busy, (m_phase != -1));
      check("model_done_excl", done0 & done1, 1'b0);
`ifdef ANDOR_ARB_STATS_EN
      check("model_gcnt0", gcnt0, m_gc0);
      check("model_gcnt1", gcnt1, m_gc1);
`endif
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int ids[$];
  int cyc_at[$];

  initial begin
    int cnt;
    int found;

    // Reset state
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_res_and", res_and, 2'b00);
    check("rst_res_or", res_or, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", {done0, done1}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 0
    req0 = 1'b1; x0 = 2'b10; y0 = 2'b11;
    @(negedge clk);
    check("single_busy", busy, 1'b1);
    @(negedge clk);
    check("single_res_early", res_and, 2'b10);
    check("single_no_done_early", done0, 1'b0);
    @(negedge clk);
    check("single_done0", done0, 1'b1);
    check("single_done1", done1, 1'b0);
    check("single_res_and", res_and, 2'b10);
    check("single_res_or", res_or, 2'b11);
    req0 = 1'b0;

    // Operand change during CALC has no effect
    @(negedge clk);
    req1 = 1'b1; x1 = 2'b01; y1 = 2'b01;
    @(negedge clk);
    x1 = 2'b10;
    @(negedge clk);
    check("stable_res_and", res_and, 2'b01);
    check("stable_res_or", res_or, 2'b01);
    @(negedge clk);
    check("stable_done1", done1, 1'b1);
    check("stable_done0", done0, 1'b0);
    req1 = 1'b0; x1 = 2'b00; y1 = 2'b00;

    // Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", {done0, done1}, 2'b00);
      check("idle_res", {res_and, res_or}, 4'b0101);
    end

    // Reset during CALC discards the transaction
    req0 = 1'b1; x0 = 2'b11; y0 = 2'b01;
    @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_res", {res_and, res_or}, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", {done0, done1}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    found = 0;
    cnt = 0;
    while (!found && cnt < 10) begin
      @(negedge clk);
      cnt++;
      if (done0) found = 1;
    end
    check("midrst_next_served", found, 1);
    check("midrst_next_latency", cnt, 3);
    check("midrst_next_res_and", res_and, 2'b01);
    check("midrst_next_res_or", res_or, 2'b11);
    req0 = 1'b0;

    // Simultaneous held requests after reset alternate 0,1,0,1
    reset_pulse();
    req0 = 1'b1; req1 = 1'b1;
    x0 = 2'b11; y0 = 2'b01; x1 = 2'b10; y1 = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done0 || done1) begin
        ids.push_back(done1 ? 1 : 0);
        cyc_at.push_back(c);
        check("rr_res", {res_and, res_or}, done1 ? 4'b0010 : 4'b0111);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_count", ids.size(), 4);
    if (ids.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rr_order", ids[k], k % 2);
        check("rr_cycle", cyc_at[k], 3 * (k + 1));
      end
    end

    // Five back-to-back grants to requester 0
    reset_pulse();
    req0 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 5; c++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    req0 = 1'b0;
    check("stats_grants", cnt, 5);
    check("stats_model_gc0", m_gc0, (5 < GMAX) ? 5 : GMAX);
    @(negedge clk);
    @(negedge clk);
`ifdef ANDOR_ARB_STATS_EN
    check("stats_gcnt0", gcnt0, 2'b11);
    check("stats_gcnt1", gcnt1, 2'b00);
`endif
    check("stats_busy_end", busy, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
